// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the scoreboarded register file.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT / CNT_W_DEFAULT : default geometry
//   REG_ZERO        : hardwired-zero register index
//   DBG_IDX_DEFAULT : register shown on the board debug tap
//   reg_idx_t / reg_data_t : index and data types at default geometry
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned ADDR_W_DEFAULT  = 5;
    localparam int unsigned CNT_W_DEFAULT   = 2;
    localparam int unsigned REG_ZERO        = 0;
    localparam int unsigned DBG_IDX_DEFAULT = 19;

    typedef logic [ADDR_W_DEFAULT-1:0] reg_idx_t;
    typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_cnt.sv
// -----------------------------------------------------------------------------
// regfile_sb_cnt
// One pending-write counter of the scoreboard. Saturates at 2**CNT_W-1 on
// increment and at 0 on decrement; simultaneous inc and dec cancel out.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : an issue targeting this register was accepted
//   dec        : write-back to this register
//   cnt        : current outstanding-write count
//   full       : count is at its maximum
// -----------------------------------------------------------------------------
module regfile_sb_cnt
    import regfile_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign full = (cnt_q == '1);

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Register file with NUM_RD combinational read ports, a per-register
// pending-write scoreboard for ID-stage hazard detection, hardwired-zero
// register 0 and a fixed debug tap.
// Build option: define REGFILE_BYPASS_EN for a write-first bypass on the read
// ports (and the matching same-cycle busy release); undefined, reads see only
// stored contents and the new value appears one cycle after the write.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rd_addr    : packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    : packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy    : port k source still has an unresolved pending write
//   we, wr_addr, wr_data : write-back port
//   iss_valid, iss_addr  : ID issues an instruction writing iss_addr
//   iss_ok     : issue accepted (pending counter of iss_addr not saturated)
//   dbg_data   : stored contents of register DBG_IDX
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned DBG_IDX = DBG_IDX_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ok,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]            regs_q [DEPTH];
    logic [DEPTH-1:0][CNT_W-1:0]  cnt;
    logic [DEPTH-1:0]             full;

    // Storage. Entry 0 is reset and never written, so it reads 0 forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wr_addr != ZERO_IDX)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write to the issue target frees a slot, so a full counter
    // still accepts the issue (inc and dec then cancel).
    assign iss_ok = !full[iss_addr] || (we && (wr_addr == iss_addr));

    // Scoreboard counters; index 0 is constant zero.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cnt
        if (i == REG_ZERO) begin : g_zero
            assign cnt[i]  = '0;
            assign full[i] = 1'b0;
        end else begin : g_live
            logic inc;
            logic dec;
            assign inc = iss_valid && iss_ok && (iss_addr == ADDR_W'(i));
            assign dec = we && (wr_addr == ADDR_W'(i));
            regfile_sb_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc),
                .dec   (dec),
                .cnt   (cnt[i]),
                .full  (full[i])
            );
        end
    end

    // Read ports
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;
        logic [CNT_W-1:0]  src_cnt;

        assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
        assign stored  = regs_q[addr];
        assign src_cnt = cnt[addr];

`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit = we && (wr_addr == addr) && (addr != ZERO_IDX);
        // Gated so a write presented during reset cannot leak through the bypass.
        assign rd_data[k*DATA_W +: DATA_W] = !rst_n ? '0 : (hit ? wr_data : stored);
        // The last outstanding producer resolving this cycle is visible via bypass.
        assign rd_busy[k] = (src_cnt != '0) && !(hit && (src_cnt == CNT_W'(1)));
`else
        assign rd_data[k*DATA_W +: DATA_W] = !rst_n ? '0 : stored;
        assign rd_busy[k] = (src_cnt != '0);
`endif
    end

    assign dbg_data = regs_q[DBG_IDX];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] D  = 32'hDEADBEEF;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ok;
    logic [31:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ok    (iss_ok),
        .dbg_data  (dbg_data)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        eok;
        logic [31:0] edbg;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic w, logic [4:0] wa, logic [31:0] wd, logic iv,
                                logic [4:0] ia, logic [4:0] r0, logic [4:0] r1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb,
                                logic eok, logic [31:0] edbg);
        vec_t v;
        v.we = w;  v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia; v.r0 = r0; v.r1 = r1;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.eok = eok; v.edbg = edbg;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ia, input logic [4:0] r0,
                         input logic [4:0] r1);
        we = w; wr_addr = wa; wr_data = wd; iss_valid = iv; iss_addr = ia;
        rd_addr = {r1, r0};
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Expected values: outputs seen before the edge that commits each vector.
        add(0, 0,  0,           0, 0, 0,  0,  0,                        0,  2'b00, 1, 0);
        add(1, 19, D,           0, 0, 19, 7,  BYP ? D : 32'd0,          0,  2'b00, 1, 0);
        add(0, 0,  0,           0, 0, 19, 0,  D,                        0,  2'b00, 1, D);
        add(1, 0,  32'h1234,    0, 0, 0,  19, 0,                        D,  2'b00, 1, D);
        add(0, 0,  0,           0, 0, 0,  0,  0,                        0,  2'b00, 1, D);
        add(1, 7,  A5,          0, 0, 19, 7,  D,        BYP ? A5 : 32'd0,   2'b00, 1, D);
        add(0, 0,  0,           0, 0, 19, 7,  D,                        A5, 2'b00, 1, D);
        // x3 scoreboard: two issues, two writes
        add(0, 0,  0,           1, 3, 3,  7,  0,                        A5, 2'b00, 1, D);
        add(0, 0,  0,           1, 3, 3,  7,  0,                        A5, 2'b01, 1, D);
        add(0, 0,  0,           0, 0, 3,  3,  0,                        0,  2'b11, 1, D);
        add(1, 3,  32'h11,      0, 0, 3,  3,  BYP ? 32'h11 : 32'd0,
                                              BYP ? 32'h11 : 32'd0,         2'b11, 1, D);
        add(1, 3,  32'h22,      0, 0, 3,  3,  BYP ? 32'h22 : 32'h11,
                                              BYP ? 32'h22 : 32'h11,
                                              BYP ? 2'b00 : 2'b11,                 1, D);
        add(0, 0,  0,           0, 0, 3,  3,  32'h22,               32'h22, 2'b00, 1, D);
        // x9 saturation
        add(0, 0,  0,           1, 9, 9,  3,  0,                    32'h22, 2'b00, 1, D);
        add(0, 0,  0,           1, 9, 9,  3,  0,                    32'h22, 2'b01, 1, D);
        add(0, 0,  0,           1, 9, 9,  3,  0,                    32'h22, 2'b01, 1, D);
        add(0, 0,  0,           1, 9, 9,  3,  0,                    32'h22, 2'b01, 0, D);
        add(0, 0,  0,           0, 9, 9,  3,  0,                    32'h22, 2'b01, 0, D);
        add(1, 9,  32'h99,      1, 9, 9,  3,  BYP ? 32'h99 : 32'd0, 32'h22, 2'b01, 1, D);
        add(0, 0,  0,           0, 9, 9,  3,  32'h99,               32'h22, 2'b01, 0, D);
        // x4 simultaneous issue + write at cnt=1
        add(0, 0,  0,           1, 4, 4,  9,  0,                    32'h99, 2'b10, 1, D);
        add(1, 4,  32'h44,      1, 4, 4,  9,  BYP ? 32'h44 : 32'd0, 32'h99,
                                              BYP ? 2'b10 : 2'b11,                 1, D);
        add(0, 0,  0,           0, 4, 4,  9,  32'h44,               32'h99, 2'b11, 1, D);
        // x0 issue
        add(0, 0,  0,           1, 0, 0,  0,  0,                        0,  2'b00, 1, D);
        add(0, 0,  0,           0, 0, 0,  0,  0,                        0,  2'b00, 1, D);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd0", rd_data[31:0], 32'd0);
        chk("reset_busy", {30'd0, rd_busy}, 32'd0);
        chk("reset_iss_ok", {31'd0, iss_ok}, 32'd1);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            drive(vq[i].we, vq[i].wa, vq[i].wd, vq[i].iv, vq[i].ia, vq[i].r0, vq[i].r1);
            @(negedge clk);
            chk($sformatf("v%0d_rd0", i), rd_data[31:0], vq[i].e0);
            chk($sformatf("v%0d_rd1", i), rd_data[63:32], vq[i].e1);
            chk($sformatf("v%0d_busy", i), {30'd0, rd_busy}, {30'd0, vq[i].eb});
            chk($sformatf("v%0d_iss_ok", i), {31'd0, iss_ok}, {31'd0, vq[i].eok});
            chk($sformatf("v%0d_dbg", i), dbg_data, vq[i].edbg);
        end

        // Mid-run reset after writing x5 (x19, x9, x4 already hold state)
        @(posedge clk);
        #1;
        drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd9, 5'd5, 5'd19);
        @(negedge clk);
        chk("pre_rst_x5_written", rd_data[31:0], BYP ? 32'h55 : 32'd0);
        @(posedge clk);
        #1;
        chk("pre_rst_x5_stored", rd_data[31:0], 32'h55);
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'h77, 1'b1, 5'd9, 5'd5, 5'd19);
        #1;
        chk("rst_rd0", rd_data[31:0], 32'd0);
        chk("rst_rd1", rd_data[63:32], 32'd0);
        chk("rst_dbg", dbg_data, 32'd0);
        chk("rst_iss_ok", {31'd0, iss_ok}, 32'd1);
        rd_addr = {5'd4, 5'd9};
        #1;
        chk("rst_busy", {30'd0, rd_busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_rd0", rd_data[31:0], 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 5'd5, 5'd19);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_x5", rd_data[31:0], 32'd0);
        chk("post_rst_dbg", dbg_data, 32'd0);
        chk("post_rst_iss_ok_x9", {31'd0, iss_ok}, 32'd1);
        rd_addr = {5'd4, 5'd9};
        #1;
        chk("post_rst_busy", {30'd0, rd_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
